// File: rtl/dmem_master.sv
// Data-memory initiator: turns single-word load/store requests from the core
// into MEMR/MEMW strobes with address/data, and returns the load data or the
// store completion on a valid/ready response channel. Every output is a
// register, so the strobes drop as soon as reset is asserted.
module dmem_master #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   // Request channel from the core
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [15:0] req_addr_i,
   input  logic [15:0] req_wdata_i,
   // Response channel to the core
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [15:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        stall_o,
   // Data memory side
   output logic        memr_o,
   output logic        memw_o,
   output logic [15:0] data_addr_o,
   output logic [15:0] write_data_o,
   input  logic [15:0] read_data_i
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   // Wait counter load value; accesses are limited to 0..15 wait cycles
   localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [15:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic        stall_q;
   logic        memr_q;
   logic        memw_q;
   logic [15:0] data_addr_q;
   logic [15:0] write_data_q;

   logic        accept;
   logic        addr_err;

   // Handshake and unsigned range check of the incoming address
   always_comb begin
      accept   = req_valid_i & req_ready_q;
      addr_err = ({16'd0, req_addr_i} >= DEPTH);
   end

   // Transaction FSM; every output is updated here as a registered value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 16'd0;
         rsp_err_q    <= 1'b0;
         stall_q      <= 1'b0;
         memr_q       <= 1'b0;
         memw_q       <= 1'b0;
         data_addr_q  <= 16'd0;
         write_data_q <= 16'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  data_addr_q  <= req_addr_i;
                  write_data_q <= req_wdata_i;
                  cnt_q        <= WaitInit;
                  req_ready_q  <= 1'b0;
                  stall_q      <= 1'b1;
                  if (addr_err) begin
                     // Out-of-range: answer at once, never touch the memory
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 16'd0;
                  end else if (req_we_i) begin
                     state_q <= StWr;
                     // With no wait cycles the first WR cycle is the write cycle
                     memw_q  <= (WaitInit == 4'd0);
                  end else begin
                     state_q <= StRd;
                     memr_q  <= 1'b1;
                  end
               end
            end

            StRd: begin
               if (cnt_q == 4'd0) begin
                  memr_q      <= 1'b0;
                  rsp_rdata_q <= read_data_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            StWr: begin
               if (cnt_q == 4'd0) begin
                  // The memory commits on this edge while MEMW is still high
                  memw_q      <= 1'b0;
                  rsp_rdata_q <= 16'd0;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StResp;
               end else begin
                  cnt_q  <= cnt_q - 4'd1;
                  // Raise MEMW only for the last cycle so exactly one write occurs
                  memw_q <= (cnt_q == 4'd1);
               end
            end

            StResp: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  stall_q     <= 1'b0;
                  state_q     <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Drive the ports straight from the state registers
   always_comb begin
      req_ready_o  = req_ready_q;
      rsp_valid_o  = rsp_valid_q;
      rsp_rdata_o  = rsp_rdata_q;
      rsp_err_o    = rsp_err_q;
      stall_o      = stall_q;
      memr_o       = memr_q;
      memw_o       = memw_q;
      data_addr_o  = data_addr_q;
      write_data_o = write_data_q;
   end

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: one instance with no wait cycles and one with three,
// each on its own behavioural data memory. Table-driven transactions plus
// hand sequences for back-pressure and reset in the middle of a store.
module tb_dmem_master;

   typedef struct {
      int          sel;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        preload;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [15:0] rsp_rdata [2];
   logic [1:0]  rsp_err;
   logic [1:0]  stall;
   logic [1:0]  memr;
   logic [1:0]  memw;
   logic [15:0] data_addr [2];
   logic [15:0] write_data [2];
   logic [15:0] rd_data [2];

   logic [15:0] mem0 [1024];
   logic [15:0] mem1 [1024];

   int n_cmp  = 0;
   int n_fail = 0;
   int rd_n [2];
   int wr_n [2];
   int both_n = 0;

   vec_t vecs [11];

   always #5 clk = ~clk;

   dmem_master #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid[0]),
      .req_ready_o  (req_ready[0]),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .rsp_valid_o  (rsp_valid[0]),
      .rsp_ready_i  (rsp_ready[0]),
      .rsp_rdata_o  (rsp_rdata[0]),
      .rsp_err_o    (rsp_err[0]),
      .stall_o      (stall[0]),
      .memr_o       (memr[0]),
      .memw_o       (memw[0]),
      .data_addr_o  (data_addr[0]),
      .write_data_o (write_data[0]),
      .read_data_i  (rd_data[0])
   );

   dmem_master #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid[1]),
      .req_ready_o  (req_ready[1]),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .rsp_valid_o  (rsp_valid[1]),
      .rsp_ready_i  (rsp_ready[1]),
      .rsp_rdata_o  (rsp_rdata[1]),
      .rsp_err_o    (rsp_err[1]),
      .stall_o      (stall[1]),
      .memr_o       (memr[1]),
      .memw_o       (memw[1]),
      .data_addr_o  (data_addr[1]),
      .write_data_o (write_data[1]),
      .read_data_i  (rd_data[1])
   );

   // Memory read path: garbage when MEMR is low so stray captures show up
   always_comb begin
      rd_data[0] = memr[0] ? mem0[data_addr[0][9:0]] : 16'hDEAD;
      rd_data[1] = memr[1] ? mem1[data_addr[1][9:0]] : 16'hDEAD;
   end

   // Memory write path and initial contents
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) begin
            mem0[i] <= 16'(i) ^ 16'hC3C3;
            mem1[i] <= 16'(i) ^ 16'hC3C3;
         end
         mem0[5]      <= 16'hBEEF;
         mem0[10'h3FF] <= 16'h5A5A;
         mem1[10'h020] <= 16'h5555;
      end else begin
         if (memw[0]) mem0[data_addr[0][9:0]] <= write_data[0];
         if (memw[1]) mem1[data_addr[1][9:0]] <= write_data[1];
      end
   end

   // Strobe monitor, sampled away from the active edge
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (memr[d]) rd_n[d] = rd_n[d] + 1;
         if (memw[d]) wr_n[d] = wr_n[d] + 1;
         if (memr[d] && memw[d]) both_n = both_n + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input int d, input string tag);
      chk($sformatf("%s_req_ready%0d", tag, d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("%s_rsp_valid%0d", tag, d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("%s_rsp_err%0d", tag, d), 32'(rsp_err[d]), 32'd0);
      chk($sformatf("%s_rsp_rdata%0d", tag, d), 32'(rsp_rdata[d]), 32'd0);
      chk($sformatf("%s_stall%0d", tag, d), 32'(stall[d]), 32'd0);
      chk($sformatf("%s_strobes%0d", tag, d), 32'({memr[d], memw[d]}), 32'd0);
      chk($sformatf("%s_data_addr%0d", tag, d), 32'(data_addr[d]), 32'd0);
      chk($sformatf("%s_write_data%0d", tag, d), 32'(write_data[d]), 32'd0);
   endtask

   // One complete request/response; starts and ends just after a posedge
   task automatic run_txn(input vec_t v, input string nm);
      int lat;
      int rd0;
      int wr0;
      int s;
      s   = v.sel;
      rd0 = rd_n[s];
      wr0 = wr_n[s];
      chk({nm, "_req_ready"}, 32'(req_ready[s]), 32'd1);
      req_we       = v.we;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      req_valid[s] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[s] = 1'b0;
      lat = 0;
      while (!rsp_valid[s] && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, "_rsp_seen"}, 32'(rsp_valid[s]), 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
      chk({nm, "_rdata"}, 32'(rsp_rdata[s]), 32'(v.exp_rdata));
      chk({nm, "_err"}, 32'(rsp_err[s]), 32'(v.exp_err));
      chk({nm, "_resp_strobes"}, 32'({memr[s], memw[s]}), 32'd0);
      rsp_ready[s] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[s] = 1'b0;
      chk({nm, "_rsp_drop"}, 32'(rsp_valid[s]), 32'd0);
      chk({nm, "_ready_back"}, 32'(req_ready[s]), 32'd1);
      chk({nm, "_addr_hold"}, 32'(data_addr[s]), 32'(v.addr));
      chk({nm, "_rd_cycles"}, 32'(rd_n[s] - rd0), 32'(v.exp_rd));
      chk({nm, "_wr_cycles"}, 32'(wr_n[s] - wr0), 32'(v.exp_wr));
   endtask

   initial begin
      int   wr_snap;
      vec_t tail;

      //             sel we    addr      wdata     rdata     err   lat rd wr
      vecs[0]  = '{0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1, 1, 0};
      vecs[1]  = '{0, 1'b1, 16'h0400, 16'h9999, 16'h0000, 1'b1, 0, 0, 0};
      vecs[2]  = '{0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 0, 0, 0};
      vecs[3]  = '{0, 1'b0, 16'h03FF, 16'h0000, 16'h5A5A, 1'b0, 1, 1, 0};
      vecs[4]  = '{0, 1'b1, 16'h03FF, 16'h1111, 16'h0000, 1'b0, 1, 0, 1};
      vecs[5]  = '{0, 1'b0, 16'h03FF, 16'h0000, 16'h1111, 1'b0, 1, 1, 0};
      vecs[6]  = '{0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 0, 0, 0};
      vecs[7]  = '{1, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 4, 0, 1};
      vecs[8]  = '{1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 4, 4, 0};
      vecs[9]  = '{1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 0, 0, 0};
      vecs[10] = '{1, 1'b0, 16'h0007, 16'h0000, 16'hC3C4, 1'b0, 4, 4, 0};

      rd_n[0] = 0; rd_n[1] = 0; wr_n[0] = 0; wr_n[1] = 0;
      rst_n     = 1'b0;
      preload   = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_we    = 1'b0;
      req_addr  = 16'd0;
      req_wdata = 16'd0;

      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) chk_reset(d, "in_reset");
      preload = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) chk_reset(d, "after_reset");

      for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));
      chk("mem1_0x10", 32'(mem1[10'h010]), 32'h1234);

      // Back-pressure: response held 5 cycles while the next request waits
      req_we       = 1'b0;
      req_addr     = 16'h0005;
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      req_we    = 1'b1;
      req_addr  = 16'h0100;
      req_wdata = 16'h7777;
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid[0]), 32'd1);
         chk($sformatf("bp%0d_rdata", c), 32'(rsp_rdata[0]), 32'hBEEF);
         chk($sformatf("bp%0d_stall", c), 32'(stall[0]), 32'd1);
         chk($sformatf("bp%0d_req_ready", c), 32'(req_ready[0]), 32'd0);
         @(posedge clk);
         #1;
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[0] = 1'b0;
      chk("bp_idle_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("bp_idle_req_ready", 32'(req_ready[0]), 32'd1);
      chk("bp_idle_stall", 32'(stall[0]), 32'd0);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      chk("bp_accept_stall", 32'(stall[0]), 32'd1);
      chk("bp_accept_addr", 32'(data_addr[0]), 32'h0100);
      @(posedge clk);
      #1;
      chk("bp_store_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_store_rdata", 32'(rsp_rdata[0]), 32'd0);
      rsp_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[0] = 1'b0;
      chk("bp_mem0_0x100", 32'(mem0[10'h100]), 32'h7777);

      // Reset during a wait cycle of a store: the write must never happen
      wr_snap      = wr_n[1];
      req_we       = 1'b1;
      req_addr     = 16'h0020;
      req_wdata    = 16'hAAAA;
      req_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_wait_memw", 32'(memw[1]), 32'd0);
      chk("rst_wait_addr", 32'(data_addr[1]), 32'h0020);
      chk("rst_wait_wdata", 32'(write_data[1]), 32'hAAAA);
      rst_n = 1'b0;
      #1;
      chk_reset(1, "mid_reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_no_write", 32'(wr_n[1] - wr_snap), 32'd0);
      chk("rst_mem1_0x20", 32'(mem1[10'h020]), 32'h5555);
      tail = '{1, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0, 4, 4, 0};
      run_txn(tail, "post_reset_load");

      chk("strobe_overlap", 32'(both_n), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
